// File: rtl/sdot_vec_loader.sv
// Streams an X and a Y vector from memory into a dot-product accelerator, kicks it,
// polls for completion and captures the result. Define SDOT_POLL_TIMEOUT_EN for a bounded poll.
module sdot_vec_loader #(
   parameter int VEC_LEN  = 96,
   parameter int POLL_MAX = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  address,
   input  logic [31:0] writedata,
   input  logic        write,
   input  logic        read,
   input  logic        chipselect,
   output logic [31:0] readdata,
   output logic        irq,
   output logic [31:0] m_address,
   output logic        m_read,
   input  logic [31:0] m_readdata,
   input  logic        m_waitrequest,
   output logic [7:0]  acc_address,
   output logic [31:0] acc_writedata,
   output logic        acc_write,
   output logic        acc_read,
   output logic        acc_chipselect,
   input  logic [31:0] acc_readdata
);

   localparam int          KW       = $clog2(2*VEC_LEN+1);
   localparam logic [31:0] VEC_W    = 32'(VEC_LEN);
   localparam logic [31:0] LAST_K   = 32'(2*VEC_LEN-1);
   localparam logic [7:0]  ADDR_CMD = 8'hFF;
   localparam logic [7:0]  ADDR_RES = 8'hFE;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_ACC_WR,
      S_KICK,
      S_POLL_RD,
      S_POLL_CHK,
      S_RES_RD,
      S_RES_CAP,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [31:0]   k_ext;
   logic [31:0]   src_x_q, src_x_d;
   logic [31:0]   src_y_q, src_y_d;
   logic [31:0]   base_x_q, base_x_d;
   logic [31:0]   base_y_q, base_y_d;
   logic [31:0]   data_q, data_d;
   logic [31:0]   result_q, result_d;
   logic [31:0]   readdata_q, readdata_d;
   logic          irq_en_q, irq_en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          timeout_q, timeout_d;

   logic          wr_en;
   logic          rd_en;
   logic          ctrl_wr;
   logic          start_req;
   logic          done_clr_req;
   logic          start_go;
   logic          poll_expired;

   assign k_ext        = 32'(k_q);
   assign wr_en        = write & chipselect;
   assign rd_en        = read & chipselect;
   assign ctrl_wr      = wr_en && (address == 3'd2);
   assign start_req    = ctrl_wr && writedata[0];
   assign done_clr_req = ctrl_wr && writedata[2];
   assign start_go     = start_req && (state_q == S_IDLE);

   assign readdata = readdata_q;
   assign irq      = done_q & irq_en_q;

`ifdef SDOT_POLL_TIMEOUT_EN
   logic [31:0] poll_q, poll_d;

   assign poll_expired = (poll_q == 32'(POLL_MAX));

   always_comb begin
      poll_d = poll_q;
      if (state_q == S_KICK) begin
         poll_d = '0;
      end else if ((state_q == S_POLL_CHK) && (acc_readdata != '0) && !poll_expired) begin
         poll_d = poll_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         poll_q <= '0;
      end else begin
         poll_q <= poll_d;
      end
   end
`else
   assign poll_expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (start_go) state_d = S_FETCH;
         S_FETCH:    if (!m_waitrequest) state_d = S_ACC_WR;
         S_ACC_WR:   state_d = (k_ext < LAST_K) ? S_FETCH : S_KICK;
         S_KICK:     state_d = S_POLL_RD;
         S_POLL_RD:  state_d = S_POLL_CHK;
         S_POLL_CHK: begin
            if (acc_readdata == '0) begin
               state_d = S_RES_RD;
            end else if (poll_expired) begin
               state_d = S_DONE;
            end else begin
               state_d = S_POLL_RD;
            end
         end
         S_RES_RD:   state_d = S_RES_CAP;
         S_RES_CAP:  state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Source bases are snapshotted at start so SRC writes mid-run only affect the next run.
   always_comb begin
      k_d        = k_q;
      src_x_d    = src_x_q;
      src_y_d    = src_y_q;
      base_x_d   = base_x_q;
      base_y_d   = base_y_q;
      data_d     = data_q;
      result_d   = result_q;
      irq_en_d   = irq_en_q;
      busy_d     = busy_q;
      done_d     = done_q;
      timeout_d  = timeout_q;
      readdata_d = readdata_q;

      if (wr_en) begin
         unique case (address)
            3'd0:    src_x_d  = writedata;
            3'd1:    src_y_d  = writedata;
            3'd2:    irq_en_d = writedata[1];
            default: ;
         endcase
      end

      if (done_clr_req) begin
         done_d = 1'b0;
      end

      if (start_go) begin
         k_d       = '0;
         base_x_d  = src_x_q;
         base_y_d  = src_y_q;
         busy_d    = 1'b1;
         done_d    = 1'b0;
         timeout_d = 1'b0;
      end

      unique case (state_q)
         S_FETCH:    if (!m_waitrequest) data_d = m_readdata;
         S_ACC_WR:   k_d = k_q + KW'(1);
         S_POLL_CHK: begin
            if ((acc_readdata != '0) && poll_expired) begin
               timeout_d = 1'b1;
               result_d  = 32'hFFFF_FFFF;
            end
         end
         S_RES_CAP:  result_d = acc_readdata;
         S_DONE: begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         default: ;
      endcase

      if (rd_en) begin
         unique case (address)
            3'd0:    readdata_d = src_x_q;
            3'd1:    readdata_d = src_y_q;
            3'd2:    readdata_d = {30'd0, irq_en_q, 1'b0};
            3'd3:    readdata_d = {29'd0, timeout_q, done_q, busy_q};
            3'd4:    readdata_d = result_q;
            default: readdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k_q        <= '0;
         src_x_q    <= '0;
         src_y_q    <= '0;
         base_x_q   <= '0;
         base_y_q   <= '0;
         data_q     <= '0;
         result_q   <= '0;
         irq_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         readdata_q <= '0;
      end else begin
         k_q        <= k_d;
         src_x_q    <= src_x_d;
         src_y_q    <= src_y_d;
         base_x_q   <= base_x_d;
         base_y_q   <= base_y_d;
         data_q     <= data_d;
         result_q   <= result_d;
         irq_en_q   <= irq_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         readdata_q <= readdata_d;
      end
   end

   // Element k maps to X for the first VEC_LEN words and to Y afterwards, modulo 2^32.
   always_comb begin
      m_read         = 1'b0;
      m_address      = '0;
      acc_write      = 1'b0;
      acc_read       = 1'b0;
      acc_chipselect = 1'b0;
      acc_address    = '0;
      acc_writedata  = '0;
      unique case (state_q)
         S_FETCH: begin
            m_read    = 1'b1;
            m_address = (k_ext < VEC_W) ? (base_x_q + (k_ext << 2))
                                        : (base_y_q + ((k_ext - VEC_W) << 2));
         end
         S_ACC_WR: begin
            acc_write      = 1'b1;
            acc_chipselect = 1'b1;
            acc_address    = k_ext[7:0];
            acc_writedata  = data_q;
         end
         S_KICK: begin
            acc_write      = 1'b1;
            acc_chipselect = 1'b1;
            acc_address    = ADDR_CMD;
            acc_writedata  = 32'd1;
         end
         S_POLL_RD: begin
            acc_read       = 1'b1;
            acc_chipselect = 1'b1;
            acc_address    = ADDR_CMD;
         end
         S_RES_RD: begin
            acc_read       = 1'b1;
            acc_chipselect = 1'b1;
            acc_address    = ADDR_RES;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sdot_vec_loader.sv
// Bench for sdot_vec_loader with VEC_LEN=4: memory and accelerator models plus a vector-level
// reference of the expected accelerator write stream, poll count and result.
module tb_sdot_vec_loader;

   localparam int VL = 4;
   localparam int PM = 8;

   logic        clk;
   logic        reset;
   logic [2:0]  address;
   logic [31:0] writedata;
   logic        write;
   logic        read;
   logic        chipselect;
   logic [31:0] readdata;
   logic        irq;
   logic [31:0] m_address;
   logic        m_read;
   logic [31:0] m_readdata;
   logic        m_waitrequest;
   logic [7:0]  acc_address;
   logic [31:0] acc_writedata;
   logic        acc_write;
   logic        acc_read;
   logic        acc_chipselect;
   logic [31:0] acc_readdata = '0;

   sdot_vec_loader #(.VEC_LEN(VL), .POLL_MAX(PM)) dut (
      .clk(clk), .reset(reset), .address(address), .writedata(writedata),
      .write(write), .read(read), .chipselect(chipselect), .readdata(readdata), .irq(irq),
      .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
      .m_waitrequest(m_waitrequest), .acc_address(acc_address),
      .acc_writedata(acc_writedata), .acc_write(acc_write), .acc_read(acc_read),
      .acc_chipselect(acc_chipselect), .acc_readdata(acc_readdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [31:0] mem [0:1023];
   logic [31:0] stall_addr = 32'h0000_0FF0;
   int          stall_seen = 0;
   int          stall_base = 0;
   int          stall_len  = 0;
   int          poll_reads = 0;
   int          poll_base  = 0;
   int          acc_nz     = 0;
   bit          acc_never  = 1'b0;
   logic [31:0] acc_res    = '0;
   int          both_hi    = 0;
   int          overlap    = 0;
   logic [39:0] wlog [$];
   logic [39:0] exp_w [$];
   int          wbase;
   int          vectors    = 0;
   int          miscompares = 0;

   assign m_readdata = mem[m_address[11:2]];

   always_comb begin
      m_waitrequest = m_read && (m_address == stall_addr) && ((stall_seen - stall_base) < stall_len);
   end

   // Accelerator answers reads one cycle later; the command word stays nonzero for acc_nz polls.
   always @(posedge clk) begin
      if (acc_chipselect && acc_write) wlog.push_back({acc_address, acc_writedata});
      if (acc_chipselect && acc_read) begin
         if (acc_address == 8'hFF) begin
            acc_readdata <= (acc_never || ((poll_reads - poll_base) < acc_nz)) ? 32'd1 : 32'd0;
            poll_reads   <= poll_reads + 1;
         end else if (acc_address == 8'hFE) begin
            acc_readdata <= acc_res;
         end else begin
            acc_readdata <= '0;
         end
      end
      if (acc_write && acc_read) both_hi <= both_hi + 1;
      if (m_read && acc_write) overlap <= overlap + 1;
      if (m_read && (m_address == stall_addr)) stall_seen <= stall_seen + 1;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; write = 1'b1; chipselect = 1'b1;
      @(negedge clk);
      write = 1'b0; chipselect = 1'b0;
   endtask

   task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a; read = 1'b1; chipselect = 1'b1;
      @(negedge clk);
      read = 1'b0; chipselect = 1'b0;
      d = readdata;
   endtask

   task automatic prep_run(input logic [31:0] bx, input logic [31:0] by, input int nz,
                           input bit never, input logic [31:0] res);
      logic [31:0] a;
      exp_w.delete();
      for (int i = 0; i < 2*VL; i++) begin
         a = (i < VL) ? bx + 32'(4*i) : by + 32'(4*(i-VL));
         exp_w.push_back({8'(i), mem[a[11:2]]});
      end
      exp_w.push_back({8'hFF, 32'd1});
      acc_nz = nz; acc_never = never; acc_res = res;
      wbase = wlog.size(); poll_base = poll_reads;
   endtask

   task automatic wait_done(input string tag);
      logic [31:0] s;
      int n = 0;
      do begin
         cpu_read(3'd3, s);
         n++;
      end while (!s[1] && n < 300);
      check({tag, " done-wait"}, {31'd0, s[1]}, 32'd1);
   endtask

   task automatic verify_run(input string tag, input logic [31:0] exp_status,
                             input logic [31:0] exp_res, input int exp_polls, input logic exp_irq);
      logic [31:0] r;
      logic [39:0] e;
      check({tag, " wr-count"}, 32'(wlog.size() - wbase), 32'(exp_w.size()));
      for (int i = 0; i < exp_w.size(); i++) begin
         e = ((wbase + i) < wlog.size()) ? wlog[wbase + i] : 40'hx;
         check($sformatf("%s wr%0d addr", tag, i), {24'd0, e[39:32]}, {24'd0, exp_w[i][39:32]});
         check($sformatf("%s wr%0d data", tag, i), e[31:0], exp_w[i][31:0]);
      end
      check({tag, " polls"}, 32'(poll_reads - poll_base), 32'(exp_polls));
      cpu_read(3'd4, r);
      check({tag, " result"}, r, exp_res);
      cpu_read(3'd3, r);
      check({tag, " status"}, r, exp_status);
      check({tag, " irq"}, {31'd0, irq}, {31'd0, exp_irq});
   endtask

   initial begin
      logic [31:0] r, bx, by, res;
      logic        ien;
      int          nz, n, cnt;

      reset = 1'b0; address = '0; writedata = '0; write = 1'b0; read = 1'b0; chipselect = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom();
      repeat (3) @(negedge clk);
      check("rst readdata", readdata, 32'd0);
      check("rst strobes", {27'd0, irq, m_read, acc_write, acc_read, acc_chipselect}, 32'd0);
      check("rst acc_address", {24'd0, acc_address}, 32'd0);
      check("rst acc_writedata", acc_writedata, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int a = 0; a < 5; a++) begin
         cpu_read(3'(a), r);
         check($sformatf("rst reg%0d", a), r, 32'd0);
      end

      $display("[TB] directed float vectors");
      for (int i = 0; i < VL; i++) begin
         mem[64 + i]  = 32'h3F80_0000;
         mem[128 + i] = 32'h4000_0000;
      end
      prep_run(32'h100, 32'h200, 3, 1'b0, 32'h4100_0000);
      cpu_write(3'd0, 32'h100);
      cpu_write(3'd1, 32'h200);
      cpu_write(3'd2, 32'd3);
      cpu_read(3'd3, r);
      check("basic busy", r, 32'd1);
      wait_done("basic");
      verify_run("basic", 32'd2, 32'h4100_0000, 4, 1'b1);
      cpu_read(3'd2, r);
      check("ctrl readback", r, 32'd2);
      cpu_write(3'd2, 32'd6);
      cpu_read(3'd3, r);
      check("done_clr status", r, 32'd0);
      check("done_clr irq", {31'd0, irq}, 32'd0);
      cpu_write(3'd5, $urandom());
      cpu_read(3'd5, r);
      check("unmapped read", r, 32'd0);
      cpu_read(3'd0, r);
      check("src_x kept", r, 32'h100);

      $display("[TB] waitrequest stall on element 2");
      for (int i = 0; i < VL; i++) mem[64 + i] = $urandom();
      stall_addr = 32'h108; stall_base = stall_seen; stall_len = 5;
      res = $urandom();
      prep_run(32'h100, 32'h200, 1, 1'b0, res);
      cpu_write(3'd2, 32'd3);
      wait_done("stall");
      verify_run("stall", 32'd2, res, 2, 1'b1);
      check("stall addr cycles", 32'(stall_seen - stall_base), 32'd6);
      stall_len = 0;

      $display("[TB] start and SRC_X write while busy");
      res = $urandom();
      prep_run(32'h300, 32'h400, 2, 1'b0, res);
      cpu_write(3'd0, 32'h300);
      cpu_write(3'd1, 32'h400);
      cpu_write(3'd2, 32'd1);
      repeat (4) @(negedge clk);
      cpu_write(3'd2, 32'd1);
      cpu_write(3'd0, 32'h500);
      wait_done("busystart");
      verify_run("busystart", 32'd2, res, 3, 1'b0);
      res = $urandom();
      prep_run(32'h500, 32'h400, 0, 1'b0, res);
      cpu_write(3'd2, 32'd1);
      wait_done("newsrc");
      verify_run("newsrc", 32'd2, res, 1, 1'b0);

      $display("[TB] randomized runs");
      for (int t = 0; t < 4; t++) begin
         bx  = (t == 0) ? 32'hFFFF_FFF4 : {20'($urandom()), 10'($urandom_range(0, 1023)), 2'b00};
         by  = {20'($urandom()), 10'($urandom_range(0, 1023)), 2'b00};
         nz  = $urandom_range(0, 5);
         ien = 1'($urandom_range(0, 1));
         res = $urandom();
         prep_run(bx, by, nz, 1'b0, res);
         cpu_write(3'd0, bx);
         cpu_write(3'd1, by);
         cpu_write(3'd2, {29'd0, 1'b1, ien, 1'b1});
         cpu_read(3'd3, r);
         check($sformatf("rand%0d clr+start", t), r, 32'd1);
         wait_done($sformatf("rand%0d", t));
         verify_run($sformatf("rand%0d", t), 32'd2, res, nz + 1, ien);
      end

`ifndef SDOT_POLL_TIMEOUT_EN
      $display("[TB] polling beyond POLL_MAX without timeout");
      res = $urandom();
      prep_run(32'h100, 32'h200, 12, 1'b0, res);
      cpu_write(3'd0, 32'h100);
      cpu_write(3'd1, 32'h200);
      cpu_write(3'd2, 32'd3);
      wait_done("longpoll");
      verify_run("longpoll", 32'd2, res, 13, 1'b1);
`else
      $display("[TB] poll timeout");
      prep_run(32'h100, 32'h200, 0, 1'b1, 32'd0);
      cpu_write(3'd0, 32'h100);
      cpu_write(3'd1, 32'h200);
      cpu_write(3'd2, 32'd3);
      wait_done("timeout");
      verify_run("timeout", 32'd6, 32'hFFFF_FFFF, PM + 1, 1'b1);
      acc_never = 1'b0;
`endif

      $display("[TB] reset during ACC_WR of k=3");
      prep_run(32'h100, 32'h200, 0, 1'b0, 32'd0);
      cpu_write(3'd2, 32'd1);
      n = 0;
      while (!(acc_write && acc_address == 8'd3) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reach k3", {31'd0, n < 200}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check("midrst strobes", {27'd0, irq, m_read, acc_write, acc_read, acc_chipselect}, 32'd0);
      check("midrst acc_address", {24'd0, acc_address}, 32'd0);
      cnt = wlog.size();
      repeat (3) @(negedge clk);
      check("midrst no writes", 32'(wlog.size()), 32'(cnt));
      reset = 1'b1;
      cpu_read(3'd3, r);
      check("midrst status", r, 32'd0);
      cpu_read(3'd0, r);
      check("midrst src_x", r, 32'd0);
      res = $urandom();
      prep_run(32'h100, 32'h200, 2, 1'b0, res);
      cpu_write(3'd0, 32'h100);
      cpu_write(3'd1, 32'h200);
      cpu_write(3'd2, 32'd3);
      wait_done("restart");
      verify_run("restart", 32'd2, res, 3, 1'b1);

      check("acc rd/wr exclusive", 32'(both_hi), 32'd0);
      check("no acc write during fetch", 32'(overlap), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sdot_vec_loader.md
SDOT_VEC_LOADER -- requirements
Module: sdot_vec_loader

Interface
REQ-001 Parameter VEC_LEN, default 96: number of 32-bit elements per vector.
REQ-002 Parameter POLL_MAX, default 1023: maximum number of completion polls.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 address  input  3  CPU slave register select.
REQ-006 writedata  input  32  CPU slave write data.
REQ-007 write, read, chipselect  input  1 each  CPU slave strobes.
REQ-008 readdata  output  32  CPU slave read data, registered.
REQ-009 irq  output  1  = STATUS.done AND CTRL.irq_en.
REQ-010 m_address  output  32  memory master byte address; m_read output 1; m_readdata input 32; m_waitrequest input 1.
REQ-011 acc_address  output  8  accelerator word address; acc_writedata output 32; acc_write, acc_read, acc_chipselect outputs 1 each; acc_readdata input 32.

Function
REQ-012 Slave map: 0 SRC_X (RW), 1 SRC_Y (RW), 2 CTRL (bit0 start write-only, self-clearing; bit1 irq_en RW; bit2 done_clr write-only), 3 STATUS (RO: bit0 busy, bit1 done, bit2 timeout), 4 RESULT (RO); addresses 5-7 read 0, writes ignored.
REQ-013 Slave reads return data on the cycle after read&chipselect; slave never stalls.
REQ-014 States: IDLE, FETCH, ACC_WR, KICK, POLL_RD, POLL_CHK, RES_RD, RES_CAP, DONE.
REQ-015 IDLE->FETCH on CTRL.start write; k cleared to 0; busy=1, done=0, timeout=0; start while busy ignored.
REQ-016 FETCH: m_read=1, m_address=SRC_X+4k for k<VEC_LEN else SRC_Y+4(k-VEC_LEN); held until m_waitrequest=0, then m_readdata latched, ->ACC_WR.
REQ-017 ACC_WR: one cycle acc_write=acc_chipselect=1, acc_address=k[7:0], acc_writedata=latched word; k increments; ->FETCH if k<2*VEC_LEN-1, else ->KICK.
REQ-018 KICK: one cycle write of 32'd1 to acc_address 255; poll counter cleared; ->POLL_RD.
REQ-019 POLL_RD: one cycle acc_read=acc_chipselect=1, acc_address=255; ->POLL_CHK.
REQ-020 POLL_CHK: sample acc_readdata; if 0 ->RES_RD; else poll counter increments, ->POLL_RD.
REQ-021 RES_RD: one-cycle read of acc_address 254; RES_CAP: acc_readdata latched into RESULT; ->DONE.
REQ-022 DONE: busy=0, done=1, ->IDLE same cycle; done sticky until done_clr or next start.
REQ-023 acc_* strobes deasserted in every state not listed above; at most one of acc_write/acc_read high per cycle.
REQ-024 Address arithmetic is 32-bit modulo 2^32; wrap is not flagged.
REQ-025 Simultaneous done_clr and start: start wins (done=0, busy=1).
REQ-026 SRC_X/SRC_Y writes while busy are accepted but affect only the next run.

Reset
REQ-027 On reset low: state IDLE, k=0, SRC_X=SRC_Y=RESULT=0, CTRL=0, STATUS=0, readdata=0, irq=0, m_read=0, all acc_* strobes 0, acc_address=0, acc_writedata=0.
REQ-028 Reset mid-run abandons the transfer immediately; no further master or accelerator cycles until a new start.

Configuration
REQ-029 Macro SDOT_POLL_TIMEOUT_EN defined: when the poll counter reaches POLL_MAX in POLL_CHK, set timeout=1, RESULT=32'hFFFF_FFFF, ->DONE.
REQ-030 Macro undefined: no poll counter; STATUS.timeout reads 0; polling continues indefinitely.

Verification
REQ-031 VEC_LEN=4, X=1.0f x4 at 0x100, Y=2.0f x4 at 0x200, start -> 8 acc writes to addresses 0..7 with matching data, then write 1 to 255.
REQ-032 Accelerator model returns 1 for 3 polls then 0, RESULT source 0x41000000 -> RESULT=0x41000000, done=1, irq=1 with irq_en=1.
REQ-033 m_waitrequest held high 5 cycles on element 2 -> m_address stable 0x108, no acc write until accepted, data order preserved.
REQ-034 Start written while busy -> ignored; k and state sequence unchanged.
REQ-035 Reset low during ACC_WR of k=3 -> all strobes 0 next cycle, STATUS=0, restart completes normally.
REQ-036 With SDOT_POLL_TIMEOUT_EN, POLL_MAX=8, model never returns 0 -> exactly 9 poll reads, timeout=1, RESULT=0xFFFFFFFF.
